alu_issue: RTL and testbench

Issue/writeback sequencer that drives the `alu` execution unit from the fetch side. It does the following for each instruction:
- accepts one instruction word and its PC over a valid/ready handshake;
- decodes the RV32I integer-ALU formats and reads operands from the register file;
- presents `instr`/`op1`/`op2` with a one-cycle `enable` pulse to the ALU;
- collects `instr_exec`/`result` in the following cycle and issues a register-file write for `rd`.

It sits between fetch/register file and the ALU. Exactly one instruction is in flight at a time.

---
 rtl/alu_issue.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback sequencer between fetch/register file and the ALU.
// One RV32I integer-ALU instruction in flight at a time:
// IDLE -> DECODE -> ISSUE -> WAIT -> WB -> IDLE.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      fetch handshake carrying in_instr and in_pc
//   rs1_addr/rs2_addr      register-file read addresses (data returns same cycle)
//   rs1_data/rs2_data      register-file read data
//   alu_instr/op1/op2      instruction and operands presented to the ALU
//   alu_enable             single-cycle issue strobe
//   alu_exec/alu_result    ALU response, valid the cycle after alu_enable
//   wb_en/wb_addr/wb_data  register-file write port
//   illegal                one-cycle pulse when an instruction is rejected
//   busy                   sequencer is not idle
//   retire_cnt             completed ALU instructions, wraps modulo 2^32
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic        alu_enable,
  input  logic        alu_exec,
  input  logic [31:0] alu_result,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        busy,
  output logic [31:0] retire_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
  localparam int unsigned OPW  = 7;

  localparam logic [OPW-1:0] OP_R     = 7'b0110011;
  localparam logic [OPW-1:0] OP_I     = 7'b0010011;
  localparam logic [OPW-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op1_next, op2_next;
  logic            decode_legal;
  logic            accept;

  // Opcodes the ALU path handles; everything else is rejected.
  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  assign accept       = (state == S_IDLE) && in_valid;
  assign decode_legal = is_alu_op(instr_q[6:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (in_valid) state_next = S_DECODE;
      S_DECODE: state_next = decode_legal ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT:   state_next = alu_exec ? S_WB : S_IDLE;
      S_WB:     state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; in_ready also drops as soon as rst rises.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    unique case (state)
      S_IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
      end
      S_DECODE: begin
        rs1_addr = instr_q[19:15];
        rs2_addr = instr_q[24:20];
      end
      default: ;
    endcase
  end

  // Operand selection; register x0 always reads as zero.
  always_comb begin
    rs1_val  = (instr_q[19:15] == RAW'(0)) ? '0 : rs1_data;
    rs2_val  = (instr_q[24:20] == RAW'(0)) ? '0 : rs2_data;
    op1_next = '0;
    op2_next = '0;
    unique case (instr_q[6:0])
      OP_R: begin
        op1_next = rs1_val;
        op2_next = rs2_val;
      end
      OP_I: begin
        op1_next = rs1_val;
        // Shift-immediates carry shamt in [24:20]; funct7 bits are not part of the value.
        if (instr_q[14:12] == 3'b001 || instr_q[14:12] == 3'b101)
          op2_next = XLEN'(instr_q[24:20]);
        else
          op2_next = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      OP_LUI: begin
        op1_next = {instr_q[31:12], 12'b0};
        op2_next = '0;
      end
      OP_AUIPC: begin
        op1_next = {instr_q[31:12], 12'b0};
        op2_next = pc_q;
      end
      default: ;
    endcase
  end

  // Registered datapath and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= '0;
      alu_instr  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_enable <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      alu_enable <= 1'b0;
      wb_en      <= 1'b0;
      illegal    <= 1'b0;

      // Opcode check at accept so the reject pulse lands in the DECODE cycle.
      if (accept) begin
        instr_q <= in_instr;
        pc_q    <= in_pc;
        illegal <= !is_alu_op(in_instr[6:0]);
      end

      if (state == S_DECODE && decode_legal) begin
        alu_instr  <= instr_q;
        alu_op1    <= op1_next;
        alu_op2    <= op2_next;
        alu_enable <= 1'b1;
      end

      if (state == S_WAIT) begin
        if (alu_exec) begin
          wb_addr    <= instr_q[11:7];
          wb_data    <= alu_result;
          wb_en      <= (instr_q[11:7] != RAW'(0));
          retire_cnt <= retire_cnt + XLEN'(1);
        end else begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a register-file and ALU model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_instr, alu_op1, alu_op2;
  logic        alu_enable;
  logic        alu_exec = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int wb_cnt   = 0;
  int ill_cnt  = 0;
  logic noexec = 1'b0;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_instr  (alu_instr),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_enable (alu_enable),
    .alu_exec   (alu_exec),
    .alu_result (alu_result),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .busy       (busy),
    .retire_cnt (retire_cnt)
  );

  // Register file model; x0 holds garbage so the forced-zero read is visible.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[0] <= 32'hDEADBEEF;
      regs[1] <= 32'd7;
      regs[2] <= 32'd5;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  // ALU model: responds the cycle after alu_enable, flag never cleared.
  always @(posedge clk) begin
    if (alu_enable) begin
      alu_exec <= !noexec;
      if (alu_instr[6:0] == 7'b0010011 && alu_instr[14:12] == 3'b101 && alu_instr[30])
        alu_result <= $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
      else
        alu_result <= alu_op1 + alu_op2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse monitor and illegal/wb_en exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_enable) en_cnt++;
      if (wb_en) wb_cnt++;
      if (illegal) ill_cnt++;
      if (illegal || wb_en) chk("excl_ill_wb", 32'(illegal & wb_en), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word for a single cycle; returns in the DECODE cycle.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    step(2);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable", 32'(alu_enable), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // ADDI x5,x0,-1
    send(32'hFFF00293, 32'h0);
    chk("A_busy", 32'(busy), 32'd1);
    chk("A_rs1", 32'(rs1_addr), 32'd0);
    step(1);
    chk("A_enable", 32'(alu_enable), 32'd1);
    chk("A_op1", alu_op1, 32'h0);
    chk("A_op2", alu_op2, 32'hFFFFFFFF);
    chk("A_instr", alu_instr, 32'hFFF00293);
    step(1);
    chk("A_enable_off", 32'(alu_enable), 32'd0);
    chk("A_wb_early", 32'(wb_en), 32'd0);
    step(1);
    chk("A_wb_en", 32'(wb_en), 32'd1);
    chk("A_wb_addr", 32'(wb_addr), 32'd5);
    chk("A_wb_data", wb_data, 32'hFFFFFFFF);
    chk("A_retire", retire_cnt, 32'd1);
    step(1);
    chk("A_ready_back", 32'(in_ready), 32'd1);
    chk("A_wb_off", 32'(wb_en), 32'd0);

    // ADD x3,x1,x2 with in_valid held high: second accept only after 5 cycles
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h4;
    step(1);
    chk("B_rs1", 32'(rs1_addr), 32'd1);
    chk("B_rs2", 32'(rs2_addr), 32'd2);
    chk("B_ready_c1", 32'(in_ready), 32'd0);
    step(1);
    chk("B_op1", alu_op1, 32'd7);
    chk("B_op2", alu_op2, 32'd5);
    step(2);
    chk("B_wb_addr", 32'(wb_addr), 32'd3);
    chk("B_wb_data", wb_data, 32'd12);
    chk("B_retire", retire_cnt, 32'd2);
    chk("B_ready_c4", 32'(in_ready), 32'd0);
    step(1);
    chk("B_ready_c5", 32'(in_ready), 32'd1);
    chk("B_busy_c5", 32'(busy), 32'd0);
    step(1);
    chk("B2_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    step(3);
    chk("B2_wb_en", 32'(wb_en), 32'd1);
    chk("B2_retire", retire_cnt, 32'd3);
    step(1);
    chk("B_en_cnt", 32'(en_cnt), 32'd3);

    // AUIPC x1,0x12345 at pc 0x100
    send(32'h12345097, 32'h100);
    step(1);
    chk("C_op1", alu_op1, 32'h12345000);
    chk("C_op2", alu_op2, 32'h100);
    step(2);
    chk("C_wb_addr", 32'(wb_addr), 32'd1);
    chk("C_wb_data", wb_data, 32'h12345100);
    chk("C_retire", retire_cnt, 32'd4);
    step(1);

    // ADDI x0,x0,1: issues, retires, no write
    send(32'h00100013, 32'h0);
    step(1);
    chk("D_enable", 32'(alu_enable), 32'd1);
    chk("D_op2", alu_op2, 32'd1);
    step(2);
    chk("D_wb_en", 32'(wb_en), 32'd0);
    chk("D_retire", retire_cnt, 32'd5);
    step(1);
    chk("D_en_cnt", 32'(en_cnt), 32'd5);
    chk("D_wb_cnt", 32'(wb_cnt), 32'd4);

    // SRAI x2,x1,4: shamt only, funct7 not in the operand
    send(32'h4040D113, 32'h0);
    step(1);
    chk("S_op1", alu_op1, 32'h12345100);
    chk("S_op2", alu_op2, 32'd4);
    step(2);
    chk("S_wb_addr", 32'(wb_addr), 32'd2);
    chk("S_wb_data", wb_data, 32'h01234510);
    chk("S_retire", retire_cnt, 32'd6);
    step(1);

    // LW x1,0(x2): rejected in DECODE
    send(32'h00012083, 32'h0);
    chk("E_illegal", 32'(illegal), 32'd1);
    chk("E_busy", 32'(busy), 32'd1);
    step(1);
    chk("E_illegal_off", 32'(illegal), 32'd0);
    chk("E_ready", 32'(in_ready), 32'd1);
    chk("E_enable", 32'(alu_enable), 32'd0);
    step(2);
    chk("E_en_cnt", 32'(en_cnt), 32'd6);
    chk("E_ill_cnt", 32'(ill_cnt), 32'd1);
    chk("E_retire", retire_cnt, 32'd6);

    // ALU does not recognise the op
    noexec = 1'b1;
    send(32'h002081B3, 32'h0);
    step(3);
    chk("F_illegal", 32'(illegal), 32'd1);
    chk("F_wb_en", 32'(wb_en), 32'd0);
    chk("F_ready", 32'(in_ready), 32'd1);
    chk("F_retire", retire_cnt, 32'd6);
    step(1);
    noexec = 1'b0;
    chk("F_illegal_off", 32'(illegal), 32'd0);
    chk("F_wb_cnt", 32'(wb_cnt), 32'd5);
    chk("F_ill_cnt", 32'(ill_cnt), 32'd2);

    // Reset during WAIT drops the instruction
    send(32'h002081B3, 32'h0);
    step(2);
    chk("G_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("G_in_ready", 32'(in_ready), 32'd0);
    chk("G_busy", 32'(busy), 32'd0);
    chk("G_op1", alu_op1, 32'h0);
    chk("G_instr", alu_instr, 32'h0);
    chk("G_wb_data", wb_data, 32'h0);
    chk("G_retire", retire_cnt, 32'd0);
    step(2);
    rst = 1'b0;
    #1;
    chk("G_ready_rel", 32'(in_ready), 32'd1);
    step(4);
    chk("G_wb_cnt", 32'(wb_cnt), 32'd5);
    chk("G_ill_cnt", 32'(ill_cnt), 32'd2);
    chk("G_retire_after", retire_cnt, 32'd0);

    // Normal operation after reset with the ALU flag still set
    send(32'hFFF00293, 32'h0);
    step(3);
    chk("H_wb_en", 32'(wb_en), 32'd1);
    chk("H_wb_data", wb_data, 32'hFFFFFFFF);
    chk("H_retire", retire_cnt, 32'd1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
